// File: rtl/pipe_ctrl_if.sv
// Bundle of control signals between pipe_ctrl and the core pipeline.
// The master modport is the controller side; the slave modport is the pipeline side.
interface pipe_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  stallreq_if_i;
    logic                  stallreq_id_i;
    logic                  stallreq_ex_i;
    logic                  stallreq_mem_i;
    logic                  jump_req_i;
    logic [ADDR_WIDTH-1:0] jump_addr_i;
    logic                  mret_i;
    logic                  int_req_i;
    logic                  int_en_i;
    logic [ADDR_WIDTH-1:0] trap_vec_i;
    logic [ADDR_WIDTH-1:0] id_pc_i;
    logic [5:0]            stall_o;
    logic                  flush_jump_o;
    logic                  flush_int_o;
    logic [ADDR_WIDTH-1:0] new_pc_o;
    logic [ADDR_WIDTH-1:0] epc_o;
    logic                  int_ack_o;
    logic [31:0]           stall_cnt_o;

    modport master (
        input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        input  jump_req_i, jump_addr_i, mret_i, int_req_i, int_en_i,
        input  trap_vec_i, id_pc_i,
        output stall_o, flush_jump_o, flush_int_o, new_pc_o, epc_o,
        output int_ack_o, stall_cnt_o
    );

    modport slave (
        output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        output jump_req_i, jump_addr_i, mret_i, int_req_i, int_en_i,
        output trap_vec_i, id_pc_i,
        input  stall_o, flush_jump_o, flush_int_o, new_pc_o, epc_o,
        input  int_ack_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall merging, EX redirects and interrupt entry.
// Optional stall-cycle counter enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    pipe_ctrl_if.master  bus
);
    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] epc_reg, epc_next;
    logic [5:0]            base_stall;
    logic [5:0]            stall;
    logic                  flush_jump;
    logic [ADDR_WIDTH-1:0] new_pc;
    logic                  jump_ok;
    logic                  mret_ok;
    logic                  int_take;

    // Latest stalling stage wins: it freezes itself and everything upstream.
    always_comb begin
        base_stall = 6'b000000;
        if (bus.stallreq_mem_i)     base_stall = 6'b011111;
        else if (bus.stallreq_ex_i) base_stall = 6'b001111;
        else if (bus.stallreq_id_i) base_stall = 6'b000111;
        else if (bus.stallreq_if_i) base_stall = 6'b000011;
    end

    // stall[3] equals base_stall[3] in IDLE and DRAIN, the only states that look at it.
    assign jump_ok  = bus.jump_req_i & ~base_stall[3];
    assign mret_ok  = bus.mret_i & ~base_stall[3];
    assign int_take = bus.int_req_i & bus.int_en_i & ~bus.stallreq_mem_i;

    always_comb begin
        state_next = state_reg;
        epc_next   = epc_reg;
        stall      = base_stall;
        flush_jump = 1'b0;
        new_pc     = '0;
        case (state_reg)
            IDLE: begin
                if (mret_ok) begin
                    flush_jump = 1'b1;
                    new_pc     = epc_reg;
                end else if (jump_ok) begin
                    flush_jump = 1'b1;
                    new_pc     = bus.jump_addr_i;
                end
                if (int_take) begin
                    state_next = DRAIN;
                    epc_next   = jump_ok ? bus.jump_addr_i : bus.id_pc_i;
                end
            end
            DRAIN: begin
                stall = base_stall | 6'b000111;
                // The jump's wrong path dies in the interrupt flush; only its target matters.
                if (jump_ok) epc_next = bus.jump_addr_i;
                if (!bus.stallreq_ex_i && !bus.stallreq_mem_i) state_next = FLUSH;
            end
            FLUSH: begin
                stall      = 6'b000000;
                new_pc     = bus.trap_vec_i;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            epc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            epc_reg   <= epc_next;
        end
    end

    assign bus.stall_o      = stall;
    assign bus.flush_jump_o = flush_jump;
    assign bus.new_pc_o     = new_pc;
    assign bus.epc_o        = epc_reg;
    assign bus.flush_int_o  = (state_reg == FLUSH);
    assign bus.int_ack_o    = (state_reg == FLUSH);

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_reg <= '0;
        end else if (stall[0] && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign bus.stall_cnt_o = stall_cnt_reg;
`else
    assign bus.stall_cnt_o = 32'd0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of the controller's rules.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.ADDR_WIDTH(32)) bus ();
    pipe_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: phase 0 = running, 1 = waiting for EX/MEM to drain, 2 = vectoring
    int          m_phase;
    logic [31:0] m_epc;
    logic [31:0] m_cnt;
    logic [5:0]  exp_stall;
    logic        exp_fj;
    logic        exp_fi;
    logic [31:0] exp_pc;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    task automatic clear_inputs();
        bus.stallreq_if_i  = 0;
        bus.stallreq_id_i  = 0;
        bus.stallreq_ex_i  = 0;
        bus.stallreq_mem_i = 0;
        bus.jump_req_i     = 0;
        bus.jump_addr_i    = 0;
        bus.mret_i         = 0;
        bus.int_req_i      = 0;
        bus.int_en_i       = 0;
        bus.trap_vec_i     = 0;
        bus.id_pc_i        = 0;
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_epc   = 0;
        m_cnt   = 0;
    endtask

    // Expected combinational outputs for the current inputs and model phase
    task automatic model_expect();
        int depth;
        depth = bus.stallreq_mem_i ? 5 : bus.stallreq_ex_i ? 4 :
                bus.stallreq_id_i ? 3 : bus.stallreq_if_i ? 2 : 0;
        exp_stall = 6'((1 << depth) - 1);
        exp_fj = 0;
        exp_fi = 0;
        exp_pc = 0;
        if (m_phase == 1) begin
            if (depth < 3) exp_stall = 6'b000111;
        end else if (m_phase == 2) begin
            exp_stall = 0;
            exp_fi = 1;
            exp_pc = bus.trap_vec_i;
        end else if (depth < 4) begin
            if (bus.mret_i) begin
                exp_fj = 1;
                exp_pc = m_epc;
            end else if (bus.jump_req_i) begin
                exp_fj = 1;
                exp_pc = bus.jump_addr_i;
            end
        end
    endtask

    // Advance the model by one clock using the inputs present before the edge
    task automatic cyc();
        int          nphase;
        logic [31:0] nepc;
        logic [31:0] ncnt;
        logic        ex_free;
        model_expect();
        ex_free = !bus.stallreq_ex_i && !bus.stallreq_mem_i;
        nphase = m_phase;
        nepc   = m_epc;
        if (m_phase == 0) begin
            if (bus.int_req_i && bus.int_en_i && !bus.stallreq_mem_i) begin
                nphase = 1;
                nepc = (bus.jump_req_i && ex_free) ? bus.jump_addr_i : bus.id_pc_i;
            end
        end else if (m_phase == 1) begin
            if (bus.jump_req_i && ex_free) nepc = bus.jump_addr_i;
            if (ex_free) nphase = 2;
        end else begin
            nphase = 0;
        end
        ncnt = m_cnt;
        if (PERF && exp_stall[0] && m_cnt != 32'hFFFF_FFFF) ncnt = m_cnt + 1;
        @(posedge clk);
        m_phase = nphase;
        m_epc   = nepc;
        m_cnt   = ncnt;
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1;
        #1;
        @(negedge clk);
        rst = 0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        model_reset();
        #1;
        n_checks++;
        if (bus.stall_o !== 6'b0 || bus.flush_int_o !== 1'b0 || bus.int_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: stall=%b fi=%b ack=%b, required 000000/0/0",
                     bus.stall_o, bus.flush_int_o, bus.int_ack_o);
        end
        n_checks++;
        if (bus.epc_o !== 32'h0 || bus.stall_cnt_o !== 32'h0 || bus.new_pc_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_regs: epc=%h cnt=%h new_pc=%h, required zeros",
                     bus.epc_o, bus.stall_cnt_o, bus.new_pc_o);
        end
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        $display("test_reset done");
    endtask

    task automatic test_stall_merge();
        bus.stallreq_ex_i = 1;
        bus.stallreq_if_i = 1;
        #1;
        n_checks++;
        if (bus.stall_o !== 6'b001111) begin
            n_fail++;
            $display("FAIL stall_ex_if: got %b required 001111", bus.stall_o);
        end
        clear_inputs();
        bus.stallreq_mem_i = 1;
        #1;
        n_checks++;
        if (bus.stall_o !== 6'b011111) begin
            n_fail++;
            $display("FAIL stall_mem: got %b required 011111", bus.stall_o);
        end
        bus.stallreq_mem_i = 0;
        bus.stallreq_id_i  = 1;
        #1;
        n_checks++;
        if (bus.stall_o !== 6'b000111) begin
            n_fail++;
            $display("FAIL stall_id: got %b required 000111", bus.stall_o);
        end
        clear_inputs();
        #1;
        n_checks++;
        if (bus.stall_o !== 6'b000000) begin
            n_fail++;
            $display("FAIL stall_none: got %b required 000000", bus.stall_o);
        end
        $display("test_stall_merge done");
    endtask

    task automatic test_jump();
        bus.jump_req_i  = 1;
        bus.jump_addr_i = 32'h100;
        #1;
        n_checks++;
        if (bus.flush_jump_o !== 1'b1 || bus.new_pc_o !== 32'h100) begin
            n_fail++;
            $display("FAIL jump_free: fj=%b pc=%h, required 1/00000100", bus.flush_jump_o, bus.new_pc_o);
        end
        bus.stallreq_ex_i = 1;
        #1;
        n_checks++;
        if (bus.flush_jump_o !== 1'b0 || bus.new_pc_o !== 32'h0) begin
            n_fail++;
            $display("FAIL jump_ex_stall: fj=%b pc=%h, required 0/00000000", bus.flush_jump_o, bus.new_pc_o);
        end
        clear_inputs();
        $display("test_jump done");
    endtask

    task automatic test_interrupt();
        bus.id_pc_i    = 32'h40;
        bus.trap_vec_i = 32'h800;
        bus.int_req_i  = 1;
        bus.int_en_i   = 1;
        cyc();
        bus.int_req_i = 0;
        bus.int_en_i  = 0;
        #1;
        n_checks++;
        if (bus.epc_o !== 32'h40 || bus.stall_o !== 6'b000111) begin
            n_fail++;
            $display("FAIL int_drain: epc=%h stall=%b, required 00000040/000111", bus.epc_o, bus.stall_o);
        end
        cyc();
        n_checks++;
        if (bus.flush_int_o !== 1'b1 || bus.int_ack_o !== 1'b1 || bus.new_pc_o !== 32'h800 ||
            bus.flush_jump_o !== 1'b0 || bus.stall_o !== 6'b0) begin
            n_fail++;
            $display("FAIL int_flush: fi=%b ack=%b pc=%h fj=%b stall=%b, required 1/1/00000800/0/000000",
                     bus.flush_int_o, bus.int_ack_o, bus.new_pc_o, bus.flush_jump_o, bus.stall_o);
        end
        cyc();
        n_checks++;
        if (bus.flush_int_o !== 1'b0 || bus.int_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL int_one_cycle: fi=%b ack=%b, required 0/0", bus.flush_int_o, bus.int_ack_o);
        end
        clear_inputs();
        $display("test_interrupt done");
    endtask

    task automatic test_int_mem_stall();
        bus.trap_vec_i     = 32'h800;
        bus.int_req_i      = 1;
        bus.int_en_i       = 1;
        bus.stallreq_mem_i = 1;
        for (int i = 0; i < 3; i++) begin
            bus.id_pc_i = 32'h1000 + 32'(i * 4);
            cyc();
        end
        bus.stallreq_mem_i = 0;
        bus.id_pc_i = 32'h2000;
        cyc();
        bus.int_req_i = 0;
        #1;
        n_checks++;
        if (bus.flush_int_o !== 1'b0 || bus.stall_o !== 6'b000111 || bus.epc_o !== 32'h2000) begin
            n_fail++;
            $display("FAIL int_mem_hold: fi=%b stall=%b epc=%h, required 0/000111/00002000",
                     bus.flush_int_o, bus.stall_o, bus.epc_o);
        end
        cyc();
        n_checks++;
        if (bus.flush_int_o !== 1'b1) begin
            n_fail++;
            $display("FAIL int_mem_flush: fi=%b required 1", bus.flush_int_o);
        end
        cyc();
        clear_inputs();
        $display("test_int_mem_stall done");
    endtask

    task automatic test_drain_ex_stall();
        int fi_seen;
        bus.trap_vec_i = 32'h800;
        bus.int_req_i  = 1;
        bus.int_en_i   = 1;
        cyc();
        bus.int_req_i     = 0;
        bus.stallreq_ex_i = 1;
        fi_seen = 0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            if (bus.flush_int_o === 1'b1) fi_seen++;
        end
        n_checks++;
        if (fi_seen != 0 || bus.stall_o !== 6'b001111) begin
            n_fail++;
            $display("FAIL drain_ex_hold: early flushes=%0d stall=%b, required 0/001111", fi_seen, bus.stall_o);
        end
        bus.stallreq_ex_i = 0;
        cyc();
        n_checks++;
        if (bus.flush_int_o !== 1'b1 || bus.new_pc_o !== 32'h800) begin
            n_fail++;
            $display("FAIL drain_ex_flush: fi=%b pc=%h, required 1/00000800", bus.flush_int_o, bus.new_pc_o);
        end
        cyc();
        clear_inputs();
        $display("test_drain_ex_stall done");
    endtask

    task automatic test_drain_jump_mret();
        bus.id_pc_i   = 32'h40;
        bus.int_req_i = 1;
        bus.int_en_i  = 1;
        cyc();
        bus.int_req_i   = 0;
        bus.jump_req_i  = 1;
        bus.jump_addr_i = 32'h200;
        #1;
        n_checks++;
        if (bus.flush_jump_o !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_jump_fj: got %b required 0", bus.flush_jump_o);
        end
        cyc();
        bus.jump_req_i = 0;
        n_checks++;
        if (bus.epc_o !== 32'h200) begin
            n_fail++;
            $display("FAIL drain_jump_epc: got %h required 00000200", bus.epc_o);
        end
        cyc();
        bus.mret_i = 1;
        #1;
        n_checks++;
        if (bus.flush_jump_o !== 1'b1 || bus.new_pc_o !== 32'h200) begin
            n_fail++;
            $display("FAIL mret_redirect: fj=%b pc=%h, required 1/00000200", bus.flush_jump_o, bus.new_pc_o);
        end
        clear_inputs();
        $display("test_drain_jump_mret done");
    endtask

    task automatic test_reset_in_drain();
        bus.id_pc_i   = 32'h80;
        bus.int_req_i = 1;
        bus.int_en_i  = 1;
        cyc();
        clear_inputs();
        #2;
        rst = 1;
        #1;
        n_checks++;
        if (bus.stall_o !== 6'b0 || bus.epc_o !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_drain_async: stall=%b epc=%h, required 000000/00000000", bus.stall_o, bus.epc_o);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 0;
        model_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.int_ack_o !== 1'b0 || bus.flush_int_o !== 1'b0 || bus.stall_cnt_o !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_drain_noack: ack=%b fi=%b cnt=%h, required 0/0/0", bus.int_ack_o,
                     bus.flush_int_o, bus.stall_cnt_o);
        end
        $display("test_reset_in_drain done");
    endtask

    task automatic test_perf();
        logic [31:0] want;
        clear_inputs();
        pulse_reset();
        bus.stallreq_if_i = 1;
        for (int i = 0; i < 5; i++) cyc();
        bus.stallreq_if_i = 0;
        #1;
        want = PERF ? 32'd5 : 32'd0;
        n_checks++;
        if (bus.stall_cnt_o !== want) begin
            n_fail++;
            $display("FAIL perf_count: got %0d required %0d", bus.stall_cnt_o, want);
        end
        $display("test_perf done");
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            bus.stallreq_if_i  = ($urandom_range(0, 5) == 0);
            bus.stallreq_id_i  = ($urandom_range(0, 6) == 0);
            bus.stallreq_ex_i  = ($urandom_range(0, 5) == 0);
            bus.stallreq_mem_i = ($urandom_range(0, 7) == 0);
            bus.jump_req_i     = ($urandom_range(0, 3) == 0);
            bus.jump_addr_i    = $urandom & 32'hFFFF_FFFC;
            bus.mret_i         = ($urandom_range(0, 7) == 0);
            bus.int_req_i      = ($urandom_range(0, 5) == 0);
            bus.int_en_i       = ($urandom_range(0, 1) == 0);
            bus.trap_vec_i     = $urandom & 32'hFFFF_FFFC;
            bus.id_pc_i        = $urandom & 32'hFFFF_FFFC;
            #1;
            model_expect();
            n_checks++;
            if (bus.stall_o !== exp_stall || bus.flush_jump_o !== exp_fj || bus.new_pc_o !== exp_pc ||
                bus.flush_int_o !== exp_fi || bus.int_ack_o !== exp_fi) begin
                n_fail++;
                errs++;
                $display("FAIL rand_comb cycle %0d: stall=%b fj=%b pc=%h fi=%b ack=%b, required %b/%b/%h/%b/%b",
                         i, bus.stall_o, bus.flush_jump_o, bus.new_pc_o, bus.flush_int_o, bus.int_ack_o,
                         exp_stall, exp_fj, exp_pc, exp_fi, exp_fi);
            end
            cyc();
            n_checks++;
            if (bus.epc_o !== m_epc || bus.stall_cnt_o !== m_cnt) begin
                n_fail++;
                errs++;
                $display("FAIL rand_regs cycle %0d: epc=%h cnt=%0d, required %h/%0d",
                         i, bus.epc_o, bus.stall_cnt_o, m_epc, m_cnt);
            end
        end
        clear_inputs();
        $display("test_random done, %0d mismatching cycles", errs);
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_stall_merge();
        test_jump();
        test_interrupt();
        test_int_mem_stall();
        test_drain_ex_stall();
        test_drain_jump_mret();
        test_reset_in_drain();
        test_perf();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the in-order core. Merges per-stage stall requests into the 6-bit stall vector, qualifies branch/jump and `mret` redirects from EX, and runs the interrupt-entry sequence: drain, flush, vector. Its `new_pc_o`, `flush_jump_o`, `flush_int_o` and `stall_o` drive the PC register and the pipeline stage registers directly.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: width of all address buses.

Ports:
- `clk_i`  in  1  core clock; all state updates on rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `stallreq_if_i`, `stallreq_id_i`, `stallreq_ex_i`, `stallreq_mem_i`  in  1 each  per-stage stall requests.
- `jump_req_i`  in  1  taken branch/jump resolved in EX.
- `jump_addr_i`  in  ADDR_WIDTH  target of the EX jump.
- `mret_i`  in  1  `mret` executing in EX.
- `int_req_i`  in  1  level interrupt request.
- `int_en_i`  in  1  global interrupt enable (CSR).
- `trap_vec_i`  in  ADDR_WIDTH  interrupt vector address.
- `id_pc_i`  in  ADDR_WIDTH  PC of the instruction currently in ID.
- `stall_o`  out  6  bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = STOP.
- `flush_jump_o`  out  1  redirect PC to `new_pc_o` (jump/`mret`).
- `flush_int_o`  out  1  interrupt redirect and flush of IF/ID/EX.
- `new_pc_o`  out  ADDR_WIDTH  redirect target.
- `epc_o`  out  ADDR_WIDTH  saved return address.
- `int_ack_o`  out  1  one-cycle pulse when the interrupt is taken.
- `stall_cnt_o`  out  32  stall-cycle counter (see Configuration).

## Operation
- Base stall vector (combinational), latest requesting stage wins:
  - `stallreq_mem_i` -> 011111
  - `stallreq_ex_i` -> 001111
  - `stallreq_id_i` -> 000111
  - `stallreq_if_i` -> 000011
  - none -> 000000
- FSM states: IDLE, DRAIN, FLUSH.
- IDLE
  - `stall_o` = base.
  - `mret_i & !stall_o[3]` -> `flush_jump_o`=1, `new_pc_o`=`epc_o`. `mret_i` takes priority over `jump_req_i`.
  - Else `jump_req_i & !stall_o[3]` -> `flush_jump_o`=1, `new_pc_o`=`jump_addr_i`.
  - `int_req_i & int_en_i & !stallreq_mem_i` at an edge -> DRAIN. Same edge: `epc_o` <= `jump_addr_i` if a qualified jump is present that cycle, else `id_pc_i`. A simultaneous jump still asserts `flush_jump_o` in that cycle.
- DRAIN
  - `stall_o` = base | 000111: no new instruction enters EX; EX/MEM/WB retire.
  - Qualified `jump_req_i` -> `epc_o` <= `jump_addr_i`. `flush_jump_o` stays 0 because the wrong path is discarded by the interrupt flush.
  - `mret_i` is ignored.
  - Leaves to FLUSH at the first edge where `stallreq_ex_i` and `stallreq_mem_i` are both 0.
  - The interrupt is committed: deassertion of `int_req_i` or `int_en_i` does not abort it.
- FLUSH
  - Exactly one cycle.
  - `flush_int_o`=1, `int_ack_o`=1, `new_pc_o`=`trap_vec_i`, `stall_o`=000000, `flush_jump_o`=0.
  - Next state IDLE.
- `new_pc_o` = 0 whenever no redirect is active.

## Timing
- Reset (async):
  - state IDLE; `epc_o`=0; `stall_cnt_o`=0.
  - `flush_int_o`=`int_ack_o`=0. Both are decoded from the state register and are glitch-free.
- `stall_o`, `flush_jump_o` and `new_pc_o` are combinational from inputs and state; no register stage.
- Interrupt latency:
  - `int_req_i` sampled at edge k.
  - DRAIN occupies cycle k+1 at minimum.
  - `flush_int_o` is high in cycle k+2.
  - The PC holds `trap_vec_i` after the k+2 edge.
  - Each cycle of `stallreq_ex_i`/`stallreq_mem_i` in DRAIN adds one cycle.
- Interrupt already in DRAIN/FLUSH: new `int_req_i` is ignored until IDLE. A still-asserted request is re-evaluated in the first IDLE cycle.
- Reset asserted mid-DRAIN or mid-FLUSH: immediate return to IDLE; no `int_ack_o`; `epc_o` cleared.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_cnt_o` increments by 1 on every edge where `stall_o[0]`=1.
  - Saturates at 32'hFFFF_FFFF.
- Undefined:
  - `stall_cnt_o` is tied to 0.
  - No counter register is synthesized.

## Test plan
- `stallreq_ex_i`=1 and `stallreq_if_i`=1 together -> `stall_o`=001111. Then `stallreq_mem_i` alone -> 011111. All requests low -> 000000.
- `jump_req_i`=1, `jump_addr_i`=32'h100 with no stall -> `flush_jump_o`=1, `new_pc_o`=32'h100. Same with `stallreq_ex_i`=1 -> `flush_jump_o`=0.
- `int_req_i`=`int_en_i`=1, `id_pc_i`=32'h40, no stalls, `trap_vec_i`=32'h800:
  - `epc_o`=32'h40 after edge k.
  - `stall_o`=000111 in cycle k+1.
  - `flush_int_o`=`int_ack_o`=1, `new_pc_o`=32'h800 in cycle k+2.
- Interrupt during `stallreq_mem_i`=1 for 3 cycles -> no DRAIN entry until the request drops. Interrupt entering DRAIN with `stallreq_ex_i` held 2 cycles -> FLUSH delayed by 2 cycles.
- DRAIN with qualified jump to 32'h200 -> `epc_o`=32'h200, `flush_jump_o`=0. Later `mret_i` in IDLE -> `flush_jump_o`=1, `new_pc_o`=32'h200.
- `rst_i` pulsed in DRAIN -> state IDLE, `epc_o`=0, no `int_ack_o`. With `PIPE_CTRL_PERF_EN`, 5 stalled cycles -> `stall_cnt_o`=5.
